// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter constants, saturating update and index/tag width helpers for the branch predictor
//
// Purpose: widths and counter encodings that depend only on the top-level
// parameters, so the predictor and any future user agree on them.
// Ports: none (package).
// Configuration macro used by the predictor: BP_RAS_EN.

package bp_pkg;

    // Index width of a BTB with the given entry count (power of two).
    function automatic int bp_idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    // Tag width: PC bits left over once the index is taken off the bottom.
    function automatic int bp_tag_bits(input int pc_bit, input int entries);
        return pc_bit - $clog2(entries);
    endfunction

    // Counter saturation maximum, 2^cnt_bit - 1.
    function automatic int bp_sat_max(input int cnt_bit);
        return (1 << cnt_bit) - 1;
    endfunction

    // Weak-taken encoding: only the MSB set.
    function automatic int bp_weak_taken(input int cnt_bit);
        return 1 << (cnt_bit - 1);
    endfunction

    // Weak-not-taken encoding: one below weak-taken (all ones below the MSB).
    function automatic int bp_weak_not_taken(input int cnt_bit);
        return (1 << (cnt_bit - 1)) - 1;
    endfunction

    // Saturating up/down step of a counter of width cnt_bit.
    function automatic int bp_sat_update(input int state, input logic taken, input int cnt_bit);
        if (taken)
            return (state >= bp_sat_max(cnt_bit)) ? bp_sat_max(cnt_bit) : state + 1;
        else
            return (state == 0) ? 0 : state - 1;
    endfunction

endpackage

// File: rtl/syn_bp_ras.sv
// rtl/syn_bp_ras.sv - circular return-address stack for the branch predictor
//
// Purpose: holds return addresses pushed by calls; a push when full wraps
// over the oldest entry, a pop when empty is dropped, and a simultaneous
// push and pop replaces the top in place.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, pop         - stack operations for this cycle
//   push_data         - address pushed
//   top               - current top of stack (meaningless while empty)
//   empty             - no valid entries

module syn_bp_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int DATA_BIT  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_BIT-1:0] push_data,
    output logic [DATA_BIT-1:0] top,
    output logic                empty
);

    localparam int PTR_BIT = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_BIT-1:0] PTR_LAST = PTR_BIT'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [DATA_BIT-1:0] stack [RAS_DEPTH];
    logic [PTR_BIT-1:0]  top_ptr;
    logic [PTR_BIT-1:0]  ptr_inc;
    logic [PTR_BIT-1:0]  ptr_dec;
    logic [CNT_W-1:0]    count;

    // Explicit wrap so non-power-of-two depths still cycle correctly.
    assign ptr_inc = (top_ptr == PTR_LAST) ? '0 : top_ptr + 1'b1;
    assign ptr_dec = (top_ptr == '0) ? PTR_LAST : top_ptr - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Parked on the last slot so the first push lands in slot 0.
            top_ptr <= PTR_LAST;
            count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                stack[i] <= '0;
        end else if (push && pop) begin
            stack[top_ptr] <= push_data;
        end else if (push) begin
            stack[ptr_inc] <= push_data;
            top_ptr        <= ptr_inc;
            if (count != CNT_FULL)
                count <= count + 1'b1;
        end else if (pop && count != '0) begin
            top_ptr <= ptr_dec;
            count   <= count - 1'b1;
        end
    end

    assign top   = stack[top_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/syn_branch_predictor.sv
// rtl/syn_branch_predictor.sv - tagged BTB with saturating counters and optional return-address stack
//
// Purpose: combinational next-PC prediction for fetch, trained at posedge by
// the resolution stage. Optional return prediction via BP_RAS_EN.
// Ports:
//   clk, rst, en                 - clock, synchronous active-high reset, global enable
//   pc_4                         - fetch-stage lookup key
//   guess_pc_new/state/hit       - prediction outputs
//   update_en, update_pc_4, update_pc_remote, update_state_old,
//   update_taken, update_is_call, update_is_ret - resolved outcome
// Configuration: BP_RAS_EN defined instantiates syn_bp_ras and stores a ret flag.

module syn_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int PC_BIT    = 10,
    parameter int CNT_BIT   = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PC_BIT-1:0]  pc_4,
    output logic [PC_BIT-1:0]  guess_pc_new,
    output logic [CNT_BIT-1:0] guess_state,
    output logic               guess_hit,
    input  logic               update_en,
    input  logic [PC_BIT-1:0]  update_pc_4,
    input  logic [PC_BIT-1:0]  update_pc_remote,
    input  logic [CNT_BIT-1:0] update_state_old,
    input  logic               update_taken,
    input  logic               update_is_call,
    input  logic               update_is_ret
);

    localparam int IDX_BIT = bp_idx_bits(ENTRIES);
    localparam int TAG_BIT = bp_tag_bits(PC_BIT, ENTRIES);
    localparam logic [CNT_BIT-1:0] CNT_WT  = CNT_BIT'(bp_weak_taken(CNT_BIT));
    localparam logic [CNT_BIT-1:0] CNT_WNT = CNT_BIT'(bp_weak_not_taken(CNT_BIT));

    typedef struct packed {
        logic               valid;
        logic [TAG_BIT-1:0] tag;
        logic [PC_BIT-1:0]  target;
        logic [CNT_BIT-1:0] cnt;
        logic               ret;
    } entry_t;

    entry_t btb [ENTRIES];

    logic [IDX_BIT-1:0] l_idx, u_idx;
    logic [TAG_BIT-1:0] l_tag, u_tag;
    logic               l_hit, u_hit, pred_taken, ret_in;
    logic [PC_BIT-1:0]  pred_target;
    logic [CNT_BIT-1:0] cnt_up, cnt_down;

    assign l_idx = pc_4[IDX_BIT-1:0];
    assign l_tag = pc_4[PC_BIT-1:IDX_BIT];
    assign u_idx = update_pc_4[IDX_BIT-1:0];
    assign u_tag = update_pc_4[PC_BIT-1:IDX_BIT];

    assign l_hit = btb[l_idx].valid && (btb[l_idx].tag == l_tag);
    assign u_hit = btb[u_idx].valid && (btb[u_idx].tag == u_tag);

    // Training starts from the state fetch saw, not the current entry value.
    assign cnt_up   = CNT_BIT'(bp_sat_update(32'(update_state_old), 1'b1, CNT_BIT));
    assign cnt_down = CNT_BIT'(bp_sat_update(32'(update_state_old), 1'b0, CNT_BIT));

`ifdef BP_RAS_EN
    logic               ras_push, ras_pop, ras_empty;
    logic [PC_BIT-1:0]  ras_top;

    assign ras_push = en && update_en && update_is_call && update_taken;
    assign ras_pop  = en && update_en && update_is_ret;
    assign ret_in   = update_is_ret;

    syn_bp_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .DATA_BIT  (PC_BIT)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (update_pc_4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // An empty stack falls back to the stored target.
    assign pred_target = (btb[l_idx].ret && !ras_empty) ? ras_top : btb[l_idx].target;
`else
    logic unused_cfg;

    assign ret_in      = 1'b0;
    assign pred_target = btb[l_idx].target;
    assign unused_cfg  = ^{update_is_call, update_is_ret, btb[l_idx].ret, RAS_DEPTH[0]};
`endif

    assign pred_taken   = l_hit && btb[l_idx].cnt[CNT_BIT-1];
    assign guess_hit    = l_hit;
    assign guess_state  = l_hit ? btb[l_idx].cnt : CNT_WNT;
    assign guess_pc_new = pred_taken ? pred_target : pc_4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT, ret: 1'b0};
        end else if (en && update_en) begin
            if (update_taken) begin
                // Taken on a miss allocates over whatever sits at the index.
                btb[u_idx].valid  <= 1'b1;
                btb[u_idx].tag    <= u_tag;
                btb[u_idx].target <= update_pc_remote;
                btb[u_idx].cnt    <= u_hit ? cnt_up : CNT_WT;
                btb[u_idx].ret    <= ret_in;
            end else if (u_hit) begin
                btb[u_idx].cnt <= cnt_down;
            end
        end
    end

endmodule

// File: tb/tb_syn_branch_predictor.sv
// tb/tb_syn_branch_predictor.sv - scoreboard bench for syn_branch_predictor

module tb_syn_branch_predictor;

`ifdef BP_RAS_EN
    localparam int RAS_D = 2;
`else
    localparam int RAS_D = 4;
`endif

    logic       clk = 1'b0;
    logic       rst, en;
    logic [9:0] pc_4, guess_pc_new;
    logic [1:0] guess_state;
    logic       guess_hit;
    logic       update_en;
    logic [9:0] update_pc_4, update_pc_remote;
    logic [1:0] update_state_old;
    logic       update_taken, update_is_call, update_is_ret;

    typedef struct {
        string      name;
        logic       hit;
        logic [9:0] pc;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic chk_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    syn_branch_predictor #(
        .ENTRIES   (16),
        .PC_BIT    (10),
        .CNT_BIT   (2),
        .RAS_DEPTH (RAS_D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .pc_4             (pc_4),
        .guess_pc_new     (guess_pc_new),
        .guess_state      (guess_state),
        .guess_hit        (guess_hit),
        .update_en        (update_en),
        .update_pc_4      (update_pc_4),
        .update_pc_remote (update_pc_remote),
        .update_state_old (update_state_old),
        .update_taken     (update_taken),
        .update_is_call   (update_is_call),
        .update_is_ret    (update_is_ret)
    );

    // Monitor: the lookup output is always presented; a check is due whenever
    // stimulus flagged a lookup this cycle.
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: lookup with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if (guess_hit !== mon_e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %0b want %0b", mon_e.name, guess_hit, mon_e.hit);
                end
                n_tests++;
                if (guess_pc_new !== mon_e.pc) begin
                    n_fail++;
                    $display("FAIL %s pc: got %h want %h", mon_e.name, guess_pc_new, mon_e.pc);
                end
                n_tests++;
                if (guess_state !== mon_e.st) begin
                    n_fail++;
                    $display("FAIL %s state: got %b want %b", mon_e.name, guess_state, mon_e.st);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req   = 1'b0;
        update_en = 1'b0;
    endtask

    task automatic look(input string nm, input logic [9:0] pc, input logic h,
                        input logic [9:0] epc, input logic [1:0] st);
        exp_t e;
        e.name = nm;
        e.hit  = h;
        e.pc   = epc;
        e.st   = st;
        pc_4   = pc;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic upd(input logic [9:0] pc, input logic [9:0] rem, input logic [1:0] old,
                       input logic tk, input logic call, input logic ret);
        update_en        = 1'b1;
        update_pc_4      = pc;
        update_pc_remote = rem;
        update_state_old = old;
        update_taken     = tk;
        update_is_call   = call;
        update_is_ret    = ret;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        pc_4 = 10'h000;
        // Pending update during reset must be discarded.
        upd(10'h004, 10'h2AA, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        look("reset_defaults", 10'h004, 1'b0, 10'h004, 2'b01);

        tick(); upd(10'h010, 10'h080, 2'b01, 1'b1, 1'b0, 1'b0);
        tick(); look("alloc_predict", 10'h010, 1'b1, 10'h080, 2'b10);

        tick(); upd(10'h010, 10'h080, 2'b11, 1'b1, 1'b0, 1'b0);
                look("sat_pre", 10'h010, 1'b1, 10'h080, 2'b10);
        tick(); upd(10'h010, 10'h080, 2'b11, 1'b1, 1'b0, 1'b0);
        tick(); upd(10'h010, 10'h080, 2'b11, 1'b1, 1'b0, 1'b0);
        tick(); look("sat_hold", 10'h010, 1'b1, 10'h080, 2'b11);
                upd(10'h010, 10'h080, 2'b10, 1'b0, 1'b0, 1'b0);
        tick(); look("decay", 10'h010, 1'b1, 10'h010, 2'b01);
                upd(10'h020, 10'h0C0, 2'b01, 1'b1, 1'b0, 1'b0);
        tick(); look("alias_old", 10'h010, 1'b0, 10'h010, 2'b01);
        tick(); look("alias_new", 10'h020, 1'b1, 10'h0C0, 2'b10);

        tick(); upd(10'h030, 10'h1F0, 2'b01, 1'b1, 1'b0, 1'b0);
                look("rw_same", 10'h030, 1'b0, 10'h030, 2'b01);
        tick(); look("rw_next", 10'h030, 1'b1, 10'h1F0, 2'b10);
                upd(10'h030, 10'h1F0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick(); look("nt_01", 10'h030, 1'b1, 10'h030, 2'b01);
                upd(10'h030, 10'h1F0, 2'b01, 1'b0, 1'b0, 1'b0);
        tick(); look("nt_00", 10'h030, 1'b1, 10'h030, 2'b00);
                upd(10'h030, 10'h1F0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); look("nt_floor", 10'h030, 1'b1, 10'h030, 2'b00);
                upd(10'h045, 10'h222, 2'b01, 1'b0, 1'b0, 1'b0);
        tick(); look("miss_nt", 10'h045, 1'b0, 10'h045, 2'b01);
                en = 1'b0;
                upd(10'h050, 10'h155, 2'b01, 1'b1, 1'b0, 1'b0);
        tick(); en = 1'b1;
                look("en_low", 10'h050, 1'b0, 10'h050, 2'b01);

`ifdef BP_RAS_EN
        tick(); upd(10'h0A5, 10'h3AA, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); look("ras_empty_ret", 10'h0A5, 1'b1, 10'h3AA, 2'b10);
                upd(10'h100, 10'h155, 2'b01, 1'b1, 1'b1, 1'b0);
        tick(); upd(10'h200, 10'h155, 2'b01, 1'b1, 1'b1, 1'b0);
        tick(); upd(10'h300, 10'h155, 2'b01, 1'b1, 1'b1, 1'b0);
        tick(); look("ras_top_300", 10'h0A5, 1'b1, 10'h300, 2'b10);
                upd(10'h0B6, 10'h000, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); look("ras_top_200", 10'h0A5, 1'b1, 10'h200, 2'b10);
                upd(10'h0B6, 10'h000, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); look("ras_drained", 10'h0A5, 1'b1, 10'h3AA, 2'b10);
`endif

        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
